// File: rtl/reload_pkg.sv
// Shared types and default sizes for the reload scheduler slice.
package reload_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } rs_state_t;

  localparam int RS_W     = 4;
  localparam int RS_DEPTH = 4;

endpackage : reload_pkg

// File: rtl/reload_fifo.sv
// Single-clock FIFO holding pending reload values. The head is read
// combinationally from the storage at the read pointer, so a value pushed on
// the same edge as a pop is never seen by that pop (no bypass path).
// Handshake: push_i is only honoured while full_o is low; pop_i is only
// honoured while empty_o is low. Both may happen on the same edge.
module reload_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] diff;
  logic          do_push;
  logic          do_pop;

  // The extra pointer bit distinguishes full from empty; the difference wraps
  // modulo 2*DEPTH and is therefore the occupancy directly.
  assign diff    = wr_ptr_q - rd_ptr_q;
  assign level_o = LW'(diff);
  assign full_o  = (diff == PW'(DEPTH));
  assign empty_o = (diff == '0);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for the pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers; reset flushes the queue by clearing them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule : reload_fifo

// File: rtl/reload_scheduler.sv
// Feeds reload values to the self-reloading counter. The queue head is
// staged into cur_val, which drives load_val_o; each reload event (forced load
// or counter wrap at all-ones) consumes cur_val and restages the next head.
// Writer handshake: a value transfers on a clock edge where wr_valid_i and
// wr_ready_o are both high; the writer holds wr_data_i stable until then.
module reload_scheduler
  import reload_pkg::*;
#(
  parameter int W     = RS_W,
  parameter int DEPTH = RS_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid_i,
  input  logic [W-1:0]               wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       force_i,
  input  logic [W-1:0]               count_i,
  output logic                       load_o,
  output logic [W-1:0]               load_val_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       empty_o,
  output logic                       starve_o,
  output logic                       state_o
);

  rs_state_t    state_q, state_d;
  logic [W-1:0] cur_val_q, cur_val_d;
  logic         load_q;
  logic         starve_q, starve_d;
  logic         rl_evt;
  logic         pop;
  logic [W-1:0] head;
  logic         full;
  logic         empty;

  reload_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (wr_valid_i),
    .push_data_i (wr_data_i),
    .pop_i       (pop),
    .head_o      (head),
    .level_o     (level_o),
    .full_o      (full),
    .empty_o     (empty)
  );

  // A forced load and a wrap on the same cycle are one event.
  assign rl_evt     = load_q || (count_i == {W{1'b1}});
  assign wr_ready_o = !full;
  assign empty_o    = empty;
  assign load_o     = load_q;
  assign load_val_o = cur_val_q;
  assign starve_o   = starve_q;
  assign state_o    = state_q;

  // Next-state: PRIME fills cur_val once; RUN restages on each reload event.
  always_comb begin
    state_d   = state_q;
    cur_val_d = cur_val_q;
    starve_d  = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      PRIME: begin
        if (!empty) begin
          cur_val_d = head;
          pop       = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (rl_evt) begin
          if (!empty) begin
            cur_val_d = head;
            pop       = 1'b1;
          end else begin
            starve_d  = 1'b1;
          end
        end
      end
      default: state_d = PRIME;
    endcase
  end

  // State, staged value, force delay and starve pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PRIME;
      cur_val_q <= '0;
      load_q    <= 1'b0;
      starve_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_val_q <= cur_val_d;
      load_q    <= force_i;
      starve_q  <= starve_d;
    end
  end

endmodule : reload_scheduler

// File: doc/reload_scheduler.md
# reload_scheduler

Upstream companion to the 4-bit self-reloading counter. Holds a small queue of reload values and drives the counter's `load_val` and `load` inputs. It presents the queue head as the next reload value and advances the queue each time the counter consumes a value, whether by wrap at all-ones or by a forced load. It also reports queue starvation so software can keep the queue fed.

## Interface
Parameters:
- `W`, default 4: counter and reload value width.
- `DEPTH`, default 4: reload queue depth; must be a power of two and at least 2.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high.
- `wr_valid_i`, input, 1: reload value offered by the writer.
- `wr_data_i`, input, W: reload value.
- `wr_ready_o`, output, 1: queue can accept; equals `!full`.
- `force_i`, input, 1: request an immediate counter load.
- `count_i`, input, W: counter's current `count_o`.
- `load_o`, output, 1: drives the counter's `load_i`.
- `load_val_o`, output, W: drives the counter's `load_val_i`.
- `level_o`, output, `$clog2(DEPTH+1)`: queue occupancy, 0..DEPTH.
- `empty_o`, output, 1: `level_o == 0`.
- `starve_o`, output, 1: one-cycle pulse; a reload was consumed with no fresh value queued.

## Operation
- Push: when `wr_valid_i && wr_ready_o`, write `wr_data_i` to the queue tail. Data is held by the writer until accepted.
- Reload event, `rl_evt = load_o || (count_i == {W{1'b1}})`. On this edge the counter captures the current `load_val_o`.
- `cur_val` is a register driving `load_val_o`.
- FSM, 2 states:
  - PRIME (reset state): `cur_val` has not yet been filled. When the queue is non-empty, `cur_val <= head`, pop, and go to RUN. This happens regardless of `rl_evt`. `starve_o` never fires in PRIME.
  - RUN, on `rl_evt`:
    - Queue non-empty: `cur_val <= head`, pop.
    - Queue empty: `cur_val` holds its value, so the last value repeats, and `starve_o` pulses next cycle.
  - RUN, without `rl_evt`: hold.
  - RUN never returns to PRIME except via reset.
- Force: `load_o <= force_i`, a registered one-cycle delay. Holding `force_i` high for N cycles gives N consecutive `load_o` cycles, and each counts as a reload event.
- `load_o` and a wrap in the same cycle form one reload event with one pop.
- Simultaneous push and pop:
  - Both occur; `level_o` is unchanged.
  - Empty queue: no bypass. The pushed value is not visible to a same-cycle pop, so starve fires and the value is used at the next event.
  - Full queue: `wr_ready_o = 0`, so no push. A pop frees a slot and `wr_ready_o` rises the next cycle.
- Occupancy is tracked with W-independent pointers of `$clog2(DEPTH)+1` bits. Pointers wrap modulo 2·DEPTH.

## Timing
- Reset values:
  - `cur_val` / `load_val_o` = 0.
  - `load_o` = 0.
  - `starve_o` = 0.
  - `level_o` = 0.
  - `empty_o` = 1.
  - `wr_ready_o` = 1.
  - State = PRIME.
  - Queue pointers = 0.
- Latency:
  - `force_i` to `load_o`: 1 cycle.
  - Pop to new `load_val_o`: visible the cycle after the reload edge.
  - Push to `level_o`: 1 cycle.
- `load_val_o`, `load_o` and `starve_o` are registered outputs.
- `level_o`, `empty_o` and `wr_ready_o` are combinational from registered pointers only.
- Reset mid-operation flushes the queue and returns to PRIME; queued values are lost.
- `count_i` is sampled each cycle and must come from the same clock domain.

## Structure
- Package `reload_pkg`:
  - `typedef enum logic {PRIME, RUN} rs_state_t`.
  - Default constants `RS_W = 4` and `RS_DEPTH = 4`.
- Sub-module `reload_fifo` (parameters W, DEPTH):
  - Synchronous single-clock FIFO with push and pop.
  - Exposes head, level, full and empty.
  - Async reset clears the pointers only.
- The top level holds the FSM, `cur_val`, the `load_o` register and the starve logic.

## Test plan
- **Prime:** after reset, push 4'h3 → `load_val_o` = 3 two cycles later, state RUN, `level_o` back to 0.
- **Wrap advance:** queue {5, 9}, `cur_val` = 3, drive `count_i` = 4'hF for one cycle → next cycle `load_val_o` = 5, `level_o` = 1; repeat → 9.
- **Starve:** `cur_val` = 9, queue empty, `count_i` = 4'hF → `starve_o` pulses once, `load_val_o` stays 9.
- **Force with simultaneous wrap:** `force_i` pulses so that `load_o` = 1 in the same cycle as `count_i` = 4'hF, queue {A, B} → only A is popped, `level_o` drops by 1.
- **Full backpressure:** push 4 values with `wr_valid_i` held → `wr_ready_o` = 0 with `level_o` = 4; the 5th value is held until a reload event, then accepted the cycle after.
- **Reset mid-run:** queue {1, 2}, assert `reset` → `level_o` = 0, `load_val_o` = 0, state PRIME; a wrap in PRIME produces no `starve_o`.
